// File: rtl/sumador_pkg.sv
// rtl/sumador_pkg.sv - shared opcode encodings for the adder/accumulator block
package sumador_pkg;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_ACC = 2'd2;
  localparam logic [1:0] OP_CLR = 2'd3;

  // ACC takes the running accumulator as its first operand instead of a
  function automatic logic uses_acc(input logic [1:0] op);
    return op == OP_ACC;
  endfunction

endpackage

// File: rtl/sat_addsub.sv
// rtl/sat_addsub.sv - combinational WIDTH-bit add/subtract with optional clamping
module sat_addsub #(
  parameter int WIDTH = 4,
  parameter int SAT   = 0
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sub,
  output logic [WIDTH-1:0] res,
  output logic             carry
);

  logic [WIDTH:0] raw;

  // widen by one bit so bit WIDTH is the carry (add) or borrow (sub); clamp only when asked
  always_comb begin
    raw   = sub ? ({1'b0, x} - {1'b0, y}) : ({1'b0, x} + {1'b0, y});
    carry = raw[WIDTH];
    res   = raw[WIDTH-1:0];
    if (SAT != 0 && raw[WIDTH]) begin
      res = sub ? '0 : '1;
    end
  end

endmodule

// File: rtl/sumador_acc_hs.sv
// rtl/sumador_acc_hs.sv - registered add/sub/accumulate unit with valid/ready handshakes
module sumador_acc_hs
  import sumador_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int SAT   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enb,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic             carry,
  output logic             ovf_sticky
);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] x_opnd;
  logic [WIDTH-1:0] y_opnd;
  logic [WIDTH-1:0] res;
  logic             res_carry;
  logic             accept;

  // the output slot frees in the same cycle it drains, so a full stream has no bubble
  assign in_ready = enb & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;

  // ACC reuses the single adder with the accumulator as the left operand
  assign x_opnd = uses_acc(op) ? acc : a;
  assign y_opnd = uses_acc(op) ? a : b;

  sat_addsub #(
    .WIDTH (WIDTH),
    .SAT   (SAT)
  ) u_addsub (
    .x     (x_opnd),
    .y     (y_opnd),
    .sub   (op == OP_SUB),
    .res   (res),
    .carry (res_carry)
  );

  // output register, accumulator and sticky flag; everything holds while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      c          <= '0;
      carry      <= 1'b0;
      ovf_sticky <= 1'b0;
      acc        <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      if (op == OP_CLR) begin
        c          <= '0;
        carry      <= 1'b0;
        ovf_sticky <= 1'b0;
        acc        <= '0;
      end else begin
        c     <= res;
        carry <= res_carry;
        if (res_carry) begin
          ovf_sticky <= 1'b1;
        end
        if (op == OP_ACC) begin
          acc <= res;
        end
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sumador_acc_hs.sv
// tb/tb_sumador_acc_hs.sv - self-checking bench for sumador_acc_hs (wrap and saturating builds)
module tb_sumador_acc_hs;
  import sumador_pkg::*;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst, enb, in_valid, out_ready;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         in_ready0, in_ready1, out_valid0, out_valid1;
  logic         carry0, carry1, ovf0, ovf1;
  logic [W-1:0] c0, c1;

  always #5 clk = ~clk;

  sumador_acc_hs #(.WIDTH(W), .SAT(0)) u_wrap (
    .clk(clk), .rst(rst), .enb(enb), .in_valid(in_valid), .in_ready(in_ready0),
    .op(op), .a(a), .b(b), .out_valid(out_valid0), .out_ready(out_ready),
    .c(c0), .carry(carry0), .ovf_sticky(ovf0)
  );

  sumador_acc_hs #(.WIDTH(W), .SAT(1)) u_sat (
    .clk(clk), .rst(rst), .enb(enb), .in_valid(in_valid), .in_ready(in_ready1),
    .op(op), .a(a), .b(b), .out_valid(out_valid1), .out_ready(out_ready),
    .c(c1), .carry(carry1), .ovf_sticky(ovf1)
  );

  int total = 0;
  int bad   = 0;

  // {carry, c} expected from the wrapping and the saturating instance
  typedef struct packed {
    logic [W:0] r0;
    logic [W:0] r1;
  } exp_t;

  exp_t         q[$];
  exp_t         last;
  logic         m_ov, m_sticky;
  logic [W-1:0] m_acc0, m_acc1;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c0;
    logic         cy;
    logic [W-1:0] c1;
    logic         st;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [W:0] calc(input bit sat, input logic [1:0] o,
                                      input logic [W-1:0] aa, input logic [W-1:0] bb,
                                      input logic [W-1:0] accv);
    logic [W:0]   r;
    logic [W-1:0] x, y;
    if (o == OP_CLR) return '0;
    x = (o == OP_ACC) ? accv : aa;
    y = (o == OP_ACC) ? aa : bb;
    if (o == OP_SUB) r = {1'b0, x} - {1'b0, y};
    else             r = {1'b0, x} + {1'b0, y};
    if (sat && r[W]) r[W-1:0] = (o == OP_SUB) ? '0 : '1;
    return r;
  endfunction

  task automatic check_outputs();
    exp_t e;
    if (m_ov && q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
      e = last;
    end else begin
      e = m_ov ? q[0] : last;
    end
    chk("out_valid0", out_valid0, m_ov);
    chk("out_valid1", out_valid1, m_ov);
    chk("c0", c0, e.r0[W-1:0]);
    chk("carry0", carry0, e.r0[W]);
    chk("c1", c1, e.r1[W-1:0]);
    chk("carry1", carry1, e.r1[W]);
    chk("ovf0", ovf0, m_sticky);
    chk("ovf1", ovf1, m_sticky);
  endtask

  task automatic cyc(input logic v, input logic [1:0] o, input logic [W-1:0] aa,
                     input logic [W-1:0] bb, input logic ordy, input logic en);
    logic rdy, acc_now;
    exp_t e;
    @(negedge clk);
    in_valid = v; op = o; a = aa; b = bb; out_ready = ordy; enb = en;
    #1;
    check_outputs();
    rdy = en & (~m_ov | ordy);
    chk("in_ready0", in_ready0, rdy);
    chk("in_ready1", in_ready1, rdy);
    acc_now = v & rdy;
    if (m_ov && ordy && q.size() != 0) last = q.pop_front();
    if (acc_now) begin
      e.r0 = calc(1'b0, o, aa, bb, m_acc0);
      e.r1 = calc(1'b1, o, aa, bb, m_acc1);
      q.push_back(e);
      if (o == OP_ACC) begin
        m_acc0 = e.r0[W-1:0];
        m_acc1 = e.r1[W-1:0];
      end
      if (o == OP_CLR) begin
        m_acc0 = '0; m_acc1 = '0; m_sticky = 1'b0;
      end else if (e.r0[W]) begin
        m_sticky = 1'b1;
      end
      m_ov = 1'b1;
    end else if (ordy) begin
      m_ov = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; enb = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    last = '0; m_ov = 1'b0; m_sticky = 1'b0; m_acc0 = '0; m_acc1 = '0;
  endtask

  initial begin
    rst = 1'b1; enb = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op = OP_ADD; a = '0; b = '0;

    tbl[0]  = '{OP_ADD, 4'd9,  4'd8, 4'd1,  1'b1, 4'd15, 1'b1};
    tbl[1]  = '{OP_SUB, 4'd3,  4'd5, 4'd14, 1'b1, 4'd0,  1'b1};
    tbl[2]  = '{OP_SUB, 4'd7,  4'd2, 4'd5,  1'b0, 4'd5,  1'b1};
    tbl[3]  = '{OP_CLR, 4'd3,  4'd3, 4'd0,  1'b0, 4'd0,  1'b0};
    tbl[4]  = '{OP_ACC, 4'd6,  4'd7, 4'd6,  1'b0, 4'd6,  1'b0};
    tbl[5]  = '{OP_ACC, 4'd6,  4'd7, 4'd12, 1'b0, 4'd12, 1'b0};
    tbl[6]  = '{OP_ACC, 4'd6,  4'd7, 4'd2,  1'b1, 4'd15, 1'b1};
    tbl[7]  = '{OP_CLR, 4'd0,  4'd0, 4'd0,  1'b0, 4'd0,  1'b0};
    tbl[8]  = '{OP_ADD, 4'd15, 4'd0, 4'd15, 1'b0, 4'd15, 1'b0};
    tbl[9]  = '{OP_SUB, 4'd0,  4'd0, 4'd0,  1'b0, 4'd0,  1'b0};
    tbl[10] = '{OP_ACC, 4'd15, 4'd9, 4'd15, 1'b0, 4'd15, 1'b0};
    tbl[11] = '{OP_ACC, 4'd1,  4'd9, 4'd0,  1'b1, 4'd15, 1'b1};

    // reset state
    do_reset();
    check_outputs();

    // back-to-back stream with hand-computed results, one result per cycle
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1, tbl[i].op, tbl[i].a, tbl[i].b, 1'b1, 1'b1);
      chk("tbl_valid", out_valid0, 1'b1);
      chk("tbl_c0", c0, tbl[i].c0);
      chk("tbl_carry0", carry0, tbl[i].cy);
      chk("tbl_c1", c1, tbl[i].c1);
      chk("tbl_carry1", carry1, tbl[i].cy);
      chk("tbl_ovf", ovf1, tbl[i].st);
    end
    cyc(1'b0, OP_ADD, 4'd0, 4'd0, 1'b1, 1'b1);

    // back-pressure: ADD 2+3 held for four cycles, then release with a new op accepted
    cyc(1'b1, OP_ADD, 4'd2, 4'd3, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, OP_SUB, 4'd9, 4'd1, 1'b0, 1'b1);
      chk("stall_c0", c0, 4'd5);
      chk("stall_ready", in_ready0, 1'b0);
    end
    cyc(1'b1, OP_ADD, 4'd4, 4'd4, 1'b1, 1'b1);
    chk("release_c0", c0, 4'd8);
    cyc(1'b0, OP_ADD, 4'd0, 4'd0, 1'b1, 1'b1);
    cyc(1'b0, OP_ADD, 4'd0, 4'd0, 1'b1, 1'b1);

    // enb low: pending result drains but nothing new enters
    cyc(1'b1, OP_ADD, 4'd1, 4'd1, 1'b0, 1'b1);
    cyc(1'b1, OP_ADD, 4'd3, 4'd3, 1'b1, 1'b0);
    cyc(1'b1, OP_ADD, 4'd3, 4'd3, 1'b1, 1'b0);
    chk("enb_low_drained", out_valid0, 1'b0);

    // reset while a result is stalled, then show the accumulator restarted at zero
    cyc(1'b1, OP_ACC, 4'd5, 4'd0, 1'b0, 1'b1);
    cyc(1'b1, OP_ADD, 4'd1, 4'd1, 1'b0, 1'b1);
    do_reset();
    check_outputs();
    cyc(1'b1, OP_ACC, 4'd3, 4'd0, 1'b1, 1'b1);
    chk("acc_after_rst_c0", c0, 4'd3);
    chk("acc_after_rst_c1", c1, 4'd3);
    cyc(1'b0, OP_ADD, 4'd0, 4'd0, 1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
